// File: rtl/running_low_windowed.sv
// Sliding-window minimum: a DEPTH-sample shift window feeding a registered
// binary comparison tree of log2(DEPTH) stages, reporting the minimum and its age.
module running_low_windowed #(
  parameter int DEPTH = 8,   // power of two, >= 2
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           low_out,
  output logic [$clog2(DEPTH)-1:0]   low_idx
);

  localparam int L  = $clog2(DEPTH);
  localparam int IW = L;
  localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

  // Handshake: no backpressure. A sample is taken on every rising edge with
  // in_valid=1 (unless reset/flush), and out_valid is a one-cycle pulse that
  // marks low_out/low_idx as the result for the sample accepted L edges earlier.

  logic [WIDTH-1:0] win [DEPTH];
  logic [IW:0]      fill;
  logic [IW:0]      fill_next;
  logic             win_vld;

  assign fill_next = (fill == DEPTH_C) ? fill : fill + 1'b1;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int k = 0; k < DEPTH; k++) win[k] <= '1;
      fill    <= '0;
      win_vld <= 1'b0;
    end else if (in_valid) begin
      win[0] <= data_in;
      for (int k = 1; k < DEPTH; k++) win[k] <= win[k-1];
      fill    <= fill_next;
      win_vld <= (fill_next == DEPTH_C);
    end else begin
      win_vld <= 1'b0;
    end
  end

  genvar s, i;
  for (s = 0; s <= L; s++) begin : g_st
    localparam int N = DEPTH >> s;
    logic [WIDTH-1:0] val [N];
    logic [IW-1:0]    age [N];
    logic             vld;

    if (s == 0) begin : g_leaf
      // Leaf ages are fixed by position: window slot k holds the sample of age k.
      for (i = 0; i < N; i++) begin : g_slot
        assign val[i] = win[i];
        assign age[i] = IW'(i);
      end
      assign vld = win_vld;
    end else begin : g_node
      logic [WIDTH-1:0] nxt_val [N];
      logic [IW-1:0]    nxt_age [N];

      // Right child wins only when strictly smaller, or equal but younger.
      always_comb begin
        for (int k = 0; k < N; k++) begin
          if ((g_st[s-1].val[2*k+1] < g_st[s-1].val[2*k]) ||
              ((g_st[s-1].val[2*k+1] == g_st[s-1].val[2*k]) &&
               (g_st[s-1].age[2*k+1] <  g_st[s-1].age[2*k]))) begin
            nxt_val[k] = g_st[s-1].val[2*k+1];
            nxt_age[k] = g_st[s-1].age[2*k+1];
          end else begin
            nxt_val[k] = g_st[s-1].val[2*k];
            nxt_age[k] = g_st[s-1].age[2*k];
          end
        end
      end

      // Data only advances with a valid token, so the last stage holds its
      // value between results and across a flush.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld <= 1'b0;
          for (int k = 0; k < N; k++) begin
            val[k] <= '0;
            age[k] <= '0;
          end
        end else begin
          vld <= g_st[s-1].vld && !flush;
          if (g_st[s-1].vld && !flush) begin
            for (int k = 0; k < N; k++) begin
              val[k] <= nxt_val[k];
              age[k] <= nxt_age[k];
            end
          end
        end
      end
    end
  end

  assign out_valid = g_st[L].vld;
  assign low_out   = g_st[L].val[0];
  assign low_idx   = g_st[L].age[0];

endmodule

// File: tb/tb_running_low_windowed.sv
// Bench for running_low_windowed: directed scenarios plus a long random run,
// all compared cycle-by-cycle against a window/queue reference model.
module tb_running_low_windowed;
  localparam int DEPTH = 8;
  localparam int WIDTH = 4;
  localparam int L     = 3;
  localparam int IW    = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             out_valid;
  logic [WIDTH-1:0] low_out;
  logic [IW-1:0]    low_idx;

  running_low_windowed #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
    .flush(flush), .out_valid(out_valid), .low_out(low_out), .low_idx(low_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: window by age, fill count, and a scoreboard of results
  // due at a given edge count.
  logic [WIDTH-1:0]    win_m [DEPTH];
  int                  fill_m = 0;
  int                  due_q[$];
  logic [WIDTH+IW-1:0] exp_q[$];
  logic                exp_v = 1'b0;
  logic [WIDTH-1:0]    exp_lo = '0;
  logic [IW-1:0]       exp_idx = '0;

  task automatic step(input logic rs, input logic fl, input logic iv,
                      input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] m;
    int a;
    reset = rs; flush = fl; in_valid = iv; data_in = d;
    @(posedge clk);
    cyc++;
    if (rs || fl) begin
      for (int k = 0; k < DEPTH; k++) win_m[k] = '1;
      fill_m = 0;
      due_q.delete();
      exp_q.delete();
      if (rs) begin
        exp_lo = '0;
        exp_idx = '0;
      end
    end else if (iv) begin
      for (int k = DEPTH-1; k > 0; k--) win_m[k] = win_m[k-1];
      win_m[0] = d;
      if (fill_m < DEPTH) fill_m++;
      if (fill_m == DEPTH) begin
        m = win_m[0];
        a = 0;
        for (int k = 1; k < DEPTH; k++) if (win_m[k] < m) begin m = win_m[k]; a = k; end
        due_q.push_back(cyc + L);
        exp_q.push_back({m, IW'(a)});
      end
    end
    exp_v = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      {exp_lo, exp_idx} = exp_q.pop_front();
      exp_v = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 0, 1, 4'd3);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    checks++; if (low_out !== '0) begin failures++; $display("FAIL reset_low got=%0d want=0", low_out); end
    checks++; if (low_idx !== '0) begin failures++; $display("FAIL reset_idx got=%0d want=0", low_idx); end
  endtask

  task automatic test_descending();
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, WIDTH'(8 - i));
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL desc_early push=%0d got=%b want=0", i, out_valid); end
    end
    for (int j = 1; j <= 3; j++) begin
      step(0, 0, 0, 0);
      checks++;
      if (out_valid !== (j == 3)) begin failures++; $display("FAIL desc_latency idle=%0d got=%b want=%b", j, out_valid, (j == 3)); end
    end
    checks++; if (low_out !== 4'd1) begin failures++; $display("FAIL desc_low got=%0d want=1", low_out); end
    checks++; if (low_idx !== 3'd0) begin failures++; $display("FAIL desc_idx got=%0d want=0", low_idx); end
  endtask

  task automatic test_oldest_min();
    step(0, 0, 1, 4'd1);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 4'd9);
    for (int j = 0; j < 3; j++) begin
      step(0, 0, 0, 0);
      checks++; if (out_valid !== exp_v) begin failures++; $display("FAIL oldest_valid got=%b want=%b", out_valid, exp_v); end
    end
    checks++; if (low_out !== 4'd1 || low_idx !== 3'd7) begin failures++; $display("FAIL oldest_min got=%0d/%0d want=1/7", low_out, low_idx); end
    step(0, 0, 1, 4'd9);
    for (int j = 0; j < 3; j++) step(0, 0, 0, 0);
    checks++; if (low_out !== 4'd9 || low_idx !== 3'd0) begin failures++; $display("FAIL oldest_evict got=%0d/%0d want=9/0", low_out, low_idx); end
  endtask

  task automatic test_ties();
    for (int i = 0; i < 8; i++) step(0, 0, 1, 4'd5);
    for (int j = 0; j < 3; j++) step(0, 0, 0, 0);
    checks++; if (low_out !== 4'd5 || low_idx !== 3'd0) begin failures++; $display("FAIL tie_first got=%0d/%0d want=5/0", low_out, low_idx); end
    step(0, 0, 1, 4'd5);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || low_out !== 4'd5 || low_idx !== 3'd0) begin
      failures++; $display("FAIL tie_second got=%b/%0d/%0d want=1/5/0", out_valid, low_out, low_idx);
    end
  endtask

  task automatic test_gaps();
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int pulses = 0;
    int pos [2] = '{-1, -1};
    for (int i = 0; i < 7; i++) begin
      step(0, 0, pat[i], WIDTH'($urandom_range(0, 15)));
      if (out_valid === 1'b1) begin
        if (pulses < 2) pos[pulses] = i;
        pulses++;
        checks++; if (low_out !== exp_lo || low_idx !== exp_idx) begin failures++; $display("FAIL gap_data got=%0d/%0d want=%0d/%0d", low_out, low_idx, exp_lo, exp_idx); end
      end
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL gap_count got=%0d want=2", pulses); end
    checks++; if (pos[0] != 3 || pos[1] != 6) begin failures++; $display("FAIL gap_spacing got=%0d,%0d want=3,6", pos[0], pos[1]); end
  endtask

  task automatic test_flush();
    int pulses = 0;
    step(0, 0, 1, 4'd2);
    step(0, 0, 1, 4'd3);
    step(0, 1, 0, 0);
    checks++; if (low_out !== exp_lo || low_idx !== exp_idx) begin failures++; $display("FAIL flush_hold got=%0d/%0d want=%0d/%0d", low_out, low_idx, exp_lo, exp_idx); end
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 0, 0);
      if (out_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL flush_squash got=%0d pulses want=0", pulses); end
    step(0, 1, 1, 4'd0);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 4'd10);
      if (out_valid === 1'b1) pulses++;
    end
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 0, 0);
      if (out_valid === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL flush_refill got=%0d pulses want=0", pulses); end
    step(0, 0, 1, 4'd12);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || low_out !== 4'd10 || low_idx !== 3'd1) begin
      failures++; $display("FAIL flush_first got=%b/%0d/%0d want=1/10/1", out_valid, low_out, low_idx);
    end
  endtask

  task automatic test_random();
    logic rs, fl, iv;
    logic [WIDTH-1:0] d;
    for (int c = 0; c < 10000; c++) begin
      rs = (c >= 5000 && c < 5002);
      fl = ($urandom_range(0, 63) == 0);
      iv = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 1) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom_range(0, 15));
      step(rs, fl, iv, d);
      checks++;
      if (out_valid !== exp_v || low_out !== exp_lo || low_idx !== exp_idx) begin
        failures++;
        $display("FAIL random cyc=%0d got=%b/%0d/%0d want=%b/%0d/%0d",
                 cyc, out_valid, low_out, low_idx, exp_v, exp_lo, exp_idx);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) win_m[k] = '1;
    test_reset();
    test_descending();
    test_oldest_min();
    test_ties();
    test_gaps();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
